// File: rtl/i2s_rx.sv
// I2S receiver: recovers left/right words from an I2S stream whose bit clock
// is asynchronous to mclk and presents each completed stereo pair in parallel.
// Words shorter than DATA_RES are left-justified and flagged short. Bits past
// DATA_RES are dropped.
module i2s_rx #(
  parameter int DATA_RES = 24
) (
  input  logic                mclk,
  input  logic                reset,
  input  logic                sclk,
  input  logic                lrclk,
  input  logic                i_sdin,
  output logic [DATA_RES-1:0] o_ldout,
  output logic [DATA_RES-1:0] o_rdout,
  output logic                o_valid,
  output logic                o_short
);

  localparam int CNT_W = $clog2(DATA_RES + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DATA_RES);

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } state_t;

  // Saturating bit counter increment: stops at DATA_RES so extra bits are dropped
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c < FULL) ? c + CNT_W'(1) : FULL;
  endfunction

  // Left-justify an n-bit word held in the LSBs; missing LSBs become 0
  function automatic logic [DATA_RES-1:0] justify(input logic [DATA_RES-1:0] w,
                                                  input logic [CNT_W-1:0]    n);
    return w << (FULL - n);
  endfunction

  // Synchronizers
  logic sclk_s1, sclk_s2, sclk_s3;
  logic lr_s1, lr_s2;
  logic sd_s1, sd_s2;

  // Bit assembly
  logic [DATA_RES-1:0] shreg;
  logic [CNT_W-1:0]    count;
  logic                lr_prev;
  logic                rise;
  logic                lr_now;
  logic                bit_in;
  logic                bnd;
  logic [DATA_RES-1:0] shreg_nxt;
  logic [CNT_W-1:0]    n_nxt;

  // Completed-word stage
  logic                vld_p0;
  logic                lr_p0;
  logic [DATA_RES-1:0] word_p0;
  logic [CNT_W-1:0]    n_p0;
  logic [DATA_RES-1:0] word_j;
  logic                short_j;

  // Framing FSM and pair stage
  state_t              state, state_nxt;
  logic                load_hold;
  logic                emit;
  logic [DATA_RES-1:0] hold;
  logic                hold_short;
  logic                vld_p1;
  logic [DATA_RES-1:0] lword_p1;
  logic [DATA_RES-1:0] rword_p1;
  logic                short_p1;

  // ---- stage boundary: asynchronous inputs into the mclk domain ----
  // Two-flop synchronizers on all inputs, plus a third sclk flop for edge detect
  always_ff @(posedge mclk) begin
    if (reset) begin
      sclk_s1 <= 1'b0;
      sclk_s2 <= 1'b0;
      sclk_s3 <= 1'b0;
      lr_s1   <= 1'b0;
      lr_s2   <= 1'b0;
      sd_s1   <= 1'b0;
      sd_s2   <= 1'b0;
    end else begin
      sclk_s1 <= sclk;
      sclk_s2 <= sclk_s1;
      sclk_s3 <= sclk_s2;
      lr_s1   <= lrclk;
      lr_s2   <= lr_s1;
      sd_s1   <= i_sdin;
      sd_s2   <= sd_s1;
    end
  end

  // Rise detection and the word-in-progress update it would cause
  always_comb begin
    rise      = sclk_s2 & ~sclk_s3;
    lr_now    = lr_s2;
    bit_in    = sd_s2;
    bnd       = rise & (lr_now != lr_prev);
    shreg_nxt = (count < FULL) ? {shreg[DATA_RES-2:0], bit_in} : shreg;
    n_nxt     = sat_inc(count);
  end

  // ---- stage boundary: p0, bit assembly and word completion ----
  // Shift bits in on each sclk rise; on a word-select change close the word
  always_ff @(posedge mclk) begin
    if (reset) begin
      shreg   <= '0;
      count   <= '0;
      lr_prev <= 1'b0;
      vld_p0  <= 1'b0;
    end else begin
      vld_p0 <= bnd;
      if (rise) begin
        lr_prev <= lr_now;
        if (bnd) begin
          shreg <= '0;
          count <= '0;
        end else begin
          shreg <= shreg_nxt;
          count <= n_nxt;
        end
      end
    end
  end

  // Capture the completed word (including the boundary bit) and its length
  always_ff @(posedge mclk) begin
    if (bnd) begin
      word_p0 <= shreg_nxt;
      n_p0    <= n_nxt;
      lr_p0   <= lr_now;
    end
  end

  // Justified word and short flag for the word leaving p0
  always_comb begin
    word_j  = justify(word_p0, n_p0);
    short_j = (n_p0 < FULL);
  end

  // ---- stage boundary: p1, framing and pairing ----
  // FSM state register
  always_ff @(posedge mclk) begin
    if (reset) state <= SYNC;
    else       state <= state_nxt;
  end

  // Framing: lock onto a left-word start, then pair each left with the next right
  always_comb begin
    state_nxt = state;
    load_hold = 1'b0;
    emit      = 1'b0;
    if (vld_p0) begin
      case (state)
        SYNC: begin
          if (!lr_p0) state_nxt = LEFT;
        end
        LEFT: begin
          if (lr_p0) begin
            load_hold = 1'b1;
            state_nxt = RIGHT;
          end
        end
        RIGHT: begin
          if (!lr_p0) begin
            emit      = 1'b1;
            state_nxt = LEFT;
          end
        end
        default: state_nxt = SYNC;
      endcase
    end
  end

  // Left holding register and pair-valid control
  always_ff @(posedge mclk) begin
    if (reset) begin
      hold       <= '0;
      hold_short <= 1'b0;
      vld_p1     <= 1'b0;
    end else begin
      vld_p1 <= emit;
      if (load_hold) begin
        hold       <= word_j;
        hold_short <= short_j;
      end
    end
  end

  // Pair data travelling alongside vld_p1
  always_ff @(posedge mclk) begin
    if (emit) begin
      lword_p1 <= hold;
      rword_p1 <= word_j;
      short_p1 <= hold_short | short_j;
    end
  end

  // ---- stage boundary: p2, output registers ----
  // Outputs change only with o_valid and hold otherwise
  always_ff @(posedge mclk) begin
    if (reset) begin
      o_ldout <= '0;
      o_rdout <= '0;
      o_valid <= 1'b0;
      o_short <= 1'b0;
    end else begin
      o_valid <= vld_p1;
      o_short <= vld_p1 & short_p1;
      if (vld_p1) begin
        o_ldout <= lword_p1;
        o_rdout <= rword_p1;
      end
    end
  end

endmodule

// File: tb/tb_i2s_rx.sv
// Bench for i2s_rx: drives I2S frames (fixed and randomized timing/lengths) and
// compares every output pair with a frame-level reference model.
module tb_i2s_rx;

  localparam int DR = 24;

  logic          mclk = 1'b0;
  logic          reset = 1'b1;
  logic          sclk = 1'b0;
  logic          lrclk = 1'b0;
  logic          i_sdin = 1'b0;
  logic [DR-1:0] o_ldout;
  logic [DR-1:0] o_rdout;
  logic          o_valid;
  logic          o_short;

  i2s_rx #(.DATA_RES(DR)) dut (
    .mclk   (mclk),
    .reset  (reset),
    .sclk   (sclk),
    .lrclk  (lrclk),
    .i_sdin (i_sdin),
    .o_ldout(o_ldout),
    .o_rdout(o_rdout),
    .o_valid(o_valid),
    .o_short(o_short)
  );

  always #5 mclk = ~mclk;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  // Stream description: channel, length in bits, value in the low len bits
  bit          w_ch[$];
  int          w_len[$];
  logic [63:0] w_val[$];

  // Model expectations and observed pairs
  logic [DR-1:0] exp_l[$], exp_r[$];
  bit            exp_s[$];
  logic [DR-1:0] got_l[$], got_r[$];
  bit            got_s[$];
  int            got_cyc[$];
  int            bdy_cyc[$];

  int            stray_short = 0;
  int            unstable = 0;
  int            wide_valid = 0;
  logic          prev_valid = 1'b0;
  logic [DR-1:0] prev_l = '0, prev_r = '0;
  bit            last_lr = 1'b0;

  // Output monitor, sampled 1 ns after each rising edge
  always @(posedge mclk) begin
    cyc = cyc + 1;
    #1;
    if (o_valid === 1'b1) begin
      got_l.push_back(o_ldout);
      got_r.push_back(o_rdout);
      got_s.push_back(o_short);
      got_cyc.push_back(cyc);
    end
    if (o_short === 1'b1 && o_valid !== 1'b1) stray_short++;
    if (o_valid === 1'b1 && prev_valid === 1'b1) wide_valid++;
    if (o_valid !== 1'b1 && (o_ldout !== prev_l || o_rdout !== prev_r)) unstable++;
    prev_valid = o_valid;
    prev_l     = o_ldout;
    prev_r     = o_rdout;
  end

  function automatic logic [DR-1:0] exp_word(input logic [63:0] v, input int len);
    logic [63:0] t;
    if (len >= DR) t = v >> (len - DR);
    else           t = v << (DR - len);
    return t[DR-1:0];
  endfunction

  task automatic clear_all();
    w_ch.delete(); w_len.delete(); w_val.delete();
    exp_l.delete(); exp_r.delete(); exp_s.delete();
    got_l.delete(); got_r.delete(); got_s.delete(); got_cyc.delete();
    bdy_cyc.delete();
    stray_short = 0; unstable = 0; wide_valid = 0;
  endtask

  task automatic do_reset();
    @(negedge mclk);
    reset = 1'b1; sclk = 1'b0; lrclk = 1'b0; i_sdin = 1'b0;
    repeat (3) @(negedge mclk);
    reset = 1'b0;
    last_lr = 1'b0;
    @(negedge mclk);
    clear_all();
  endtask

  task automatic add_word(input bit ch, input int len, input logic [63:0] val);
    w_ch.push_back(ch); w_len.push_back(len); w_val.push_back(val);
  endtask

  // Frame-level model: nothing counts until a right word has ended; then each
  // left word followed by a right word forms one output pair.
  task automatic build_exp();
    bit seen_r = 1'b0, have_l = 1'b0, ls = 1'b0;
    logic [DR-1:0] lw = '0;
    for (int k = 0; k < w_ch.size(); k++) begin
      if (w_ch[k] == 1'b0) begin
        have_l = seen_r;
        lw     = exp_word(w_val[k], w_len[k]);
        ls     = (w_len[k] < DR);
      end else begin
        if (have_l) begin
          exp_l.push_back(lw);
          exp_r.push_back(exp_word(w_val[k], w_len[k]));
          exp_s.push_back(ls | (w_len[k] < DR));
        end
        seen_r = 1'b1;
        have_l = 1'b0;
      end
    end
  endtask

  task automatic send_bit(input bit lr, input bit d, input bit rnd);
    int lo, hi;
    lo = rnd ? int'($urandom_range(6, 4)) : 5;
    hi = rnd ? int'($urandom_range(4, 2)) : 3;
    @(negedge mclk);
    sclk = 1'b0; lrclk = lr; i_sdin = d;
    repeat (lo - 1) @(negedge mclk);
    sclk = 1'b1;
    if (lr != last_lr && lr == 1'b0) bdy_cyc.push_back(cyc + 1);
    last_lr = lr;
    repeat (hi) @(negedge mclk);
  endtask

  // The last bit of every word is sent with the next channel's word select
  task automatic play(input bit rnd);
    bit lr;
    for (int k = 0; k < w_ch.size(); k++) begin
      for (int j = 0; j < w_len[k]; j++) begin
        lr = (j == w_len[k] - 1) ? ~w_ch[k] : w_ch[k];
        send_bit(lr, w_val[k][w_len[k]-1-j], rnd);
      end
    end
    @(negedge mclk); sclk = 1'b0;
    repeat (12) @(negedge mclk);
  endtask

  task automatic test_reset();
    @(negedge mclk);
    reset = 1'b1; sclk = 1'b0; lrclk = 1'b0; i_sdin = 1'b0;
    repeat (3) @(negedge mclk);
    total++; if (o_ldout !== '0) $display("FAIL reset_ldout got %h want 0", o_ldout); else passed++;
    total++; if (o_rdout !== '0) $display("FAIL reset_rdout got %h want 0", o_rdout); else passed++;
    total++; if (o_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", o_valid); else passed++;
    total++; if (o_short !== 1'b0) $display("FAIL reset_short got %b want 0", o_short); else passed++;
    reset = 1'b0;
    last_lr = 1'b0;
    @(negedge mclk);
    clear_all();
  endtask

  task automatic test_standard();
    do_reset();
    add_word(1'b1, 32, 64'($urandom));
    for (int f = 0; f < 3; f++) begin
      add_word(1'b0, 32, {32'h0, 24'hA5A5A5, 8'($urandom)});
      add_word(1'b1, 32, {32'h0, 24'h3C3C3C, 8'($urandom)});
    end
    build_exp();
    play(1'b0);
    total++; if (got_l.size() != exp_l.size()) $display("FAIL std_count got %0d want %0d", got_l.size(), exp_l.size()); else passed++;
    for (int i = 0; i < exp_l.size() && i < got_l.size(); i++) begin
      total++;
      if (got_l[i] !== exp_l[i] || got_r[i] !== exp_r[i] || got_s[i] !== exp_s[i])
        $display("FAIL std_pair%0d got %h/%h/%b want %h/%h/%b", i, got_l[i], got_r[i], got_s[i], exp_l[i], exp_r[i], exp_s[i]);
      else passed++;
    end
    total++; if (stray_short + unstable + wide_valid != 0) $display("FAIL std_protocol got %0d/%0d/%0d want 0/0/0", stray_short, unstable, wide_valid); else passed++;
  endtask

  task automatic test_short();
    do_reset();
    add_word(1'b1, 16, 64'h5555);
    for (int f = 0; f < 2; f++) begin
      add_word(1'b0, 16, 64'hABCD);
      add_word(1'b1, 16, 64'h1234);
    end
    build_exp();
    play(1'b0);
    total++; if (got_l.size() != exp_l.size()) $display("FAIL short_count got %0d want %0d", got_l.size(), exp_l.size()); else passed++;
    for (int i = 0; i < exp_l.size() && i < got_l.size(); i++) begin
      total++;
      if (got_l[i] !== exp_l[i] || got_r[i] !== exp_r[i] || got_s[i] !== exp_s[i])
        $display("FAIL short_pair%0d got %h/%h/%b want %h/%h/%b", i, got_l[i], got_r[i], got_s[i], exp_l[i], exp_r[i], exp_s[i]);
      else passed++;
    end
    total++; if (stray_short + unstable + wide_valid != 0) $display("FAIL short_protocol got %0d/%0d/%0d want 0/0/0", stray_short, unstable, wide_valid); else passed++;
  endtask

  task automatic test_exact();
    do_reset();
    add_word(1'b1, 24, 64'h0F0F0F);
    for (int f = 0; f < 2; f++) begin
      add_word(1'b0, 24, 64'hFFFFFF);
      add_word(1'b1, 24, 64'h000001);
    end
    build_exp();
    play(1'b1);
    total++; if (got_l.size() != exp_l.size()) $display("FAIL exact_count got %0d want %0d", got_l.size(), exp_l.size()); else passed++;
    for (int i = 0; i < exp_l.size() && i < got_l.size(); i++) begin
      total++;
      if (got_l[i] !== exp_l[i] || got_r[i] !== exp_r[i] || got_s[i] !== exp_s[i])
        $display("FAIL exact_pair%0d got %h/%h/%b want %h/%h/%b", i, got_l[i], got_r[i], got_s[i], exp_l[i], exp_r[i], exp_s[i]);
      else passed++;
    end
    total++; if (stray_short + unstable + wide_valid != 0) $display("FAIL exact_protocol got %0d/%0d/%0d want 0/0/0", stray_short, unstable, wide_valid); else passed++;
  endtask

  task automatic test_startup_midright();
    do_reset();
    add_word(1'b1, 10, 64'($urandom));
    for (int f = 0; f < 2; f++) begin
      add_word(1'b0, 24, 64'($urandom_range(24'hFFFFFF, 0)));
      add_word(1'b1, 24, 64'($urandom_range(24'hFFFFFF, 0)));
    end
    build_exp();
    play(1'b1);
    total++; if (got_l.size() != exp_l.size()) $display("FAIL startup_count got %0d want %0d", got_l.size(), exp_l.size()); else passed++;
    for (int i = 0; i < exp_l.size() && i < got_l.size(); i++) begin
      total++;
      if (got_l[i] !== exp_l[i] || got_r[i] !== exp_r[i] || got_s[i] !== exp_s[i])
        $display("FAIL startup_pair%0d got %h/%h/%b want %h/%h/%b", i, got_l[i], got_r[i], got_s[i], exp_l[i], exp_r[i], exp_s[i]);
      else passed++;
    end
  endtask

  task automatic test_random();
    do_reset();
    add_word(1'b1, 32, 64'($urandom));
    for (int f = 0; f < 5; f++) begin
      add_word(1'b0, int'($urandom_range(32, 6)), {$urandom, $urandom});
      add_word(1'b1, int'($urandom_range(32, 6)), {$urandom, $urandom});
    end
    for (int k = 0; k < w_val.size(); k++) w_val[k] = w_val[k] & ((64'd1 << w_len[k]) - 64'd1);
    build_exp();
    play(1'b1);
    total++; if (got_l.size() != exp_l.size()) $display("FAIL rand_count got %0d want %0d", got_l.size(), exp_l.size()); else passed++;
    for (int i = 0; i < exp_l.size() && i < got_l.size(); i++) begin
      total++;
      if (got_l[i] !== exp_l[i] || got_r[i] !== exp_r[i] || got_s[i] !== exp_s[i])
        $display("FAIL rand_pair%0d got %h/%h/%b want %h/%h/%b", i, got_l[i], got_r[i], got_s[i], exp_l[i], exp_r[i], exp_s[i]);
      else passed++;
    end
    total++; if (stray_short + unstable + wide_valid != 0) $display("FAIL rand_protocol got %0d/%0d/%0d want 0/0/0", stray_short, unstable, wide_valid); else passed++;
  endtask

  task automatic test_midreset();
    logic [23:0] part;
    do_reset();
    add_word(1'b1, 24, 64'h111111);
    add_word(1'b0, 24, 64'h2468AC);
    add_word(1'b1, 24, 64'h13579B);
    play(1'b0);
    total++; if (got_l.size() != 1 || got_l[0] !== 24'h2468AC) $display("FAIL midrst_pre got %0d pairs want 1 pair 2468ac", got_l.size()); else passed++;
    // ten bits of a left word, then a one-cycle reset
    part = 24'($urandom);
    for (int j = 0; j < 10; j++) send_bit(1'b0, part[23-j], 1'b0);
    @(negedge mclk);
    sclk = 1'b0; reset = 1'b1;
    @(negedge mclk);
    reset = 1'b0;
    last_lr = 1'b0;
    total++; if (o_ldout !== '0 || o_rdout !== '0 || o_valid !== 1'b0 || o_short !== 1'b0)
      $display("FAIL midrst_outs got %h/%h/%b/%b want 0/0/0/0", o_ldout, o_rdout, o_valid, o_short);
    else passed++;
    clear_all();
    add_word(1'b0, 14, 64'(part[13:0]));
    add_word(1'b1, 24, 64'hFEDCBA);
    add_word(1'b0, 24, 64'h0A0B0C);
    add_word(1'b1, 24, 64'h808080);
    build_exp();
    play(1'b0);
    total++; if (got_l.size() != exp_l.size()) $display("FAIL midrst_count got %0d want %0d", got_l.size(), exp_l.size()); else passed++;
    for (int i = 0; i < exp_l.size() && i < got_l.size(); i++) begin
      total++;
      if (got_l[i] !== exp_l[i] || got_r[i] !== exp_r[i] || got_s[i] !== exp_s[i])
        $display("FAIL midrst_pair%0d got %h/%h/%b want %h/%h/%b", i, got_l[i], got_r[i], got_s[i], exp_l[i], exp_r[i], exp_s[i]);
      else passed++;
    end
  endtask

  task automatic test_latency();
    bit found;
    do_reset();
    add_word(1'b1, 32, 64'($urandom));
    for (int f = 0; f < 3; f++) begin
      add_word(1'b0, 32, 64'($urandom));
      add_word(1'b1, 32, 64'($urandom));
    end
    build_exp();
    play(1'b0);
    total++; if (got_cyc.size() != exp_l.size()) $display("FAIL lat_count got %0d want %0d", got_cyc.size(), exp_l.size()); else passed++;
    for (int i = 0; i < got_cyc.size(); i++) begin
      found = 1'b0;
      foreach (bdy_cyc[b]) if (got_cyc[i] - bdy_cyc[b] == 4) found = 1'b1;
      total++;
      if (!found) $display("FAIL lat_pulse%0d got valid at cycle %0d want 4 after a left boundary edge", i, got_cyc[i]);
      else passed++;
    end
    total++; if (wide_valid != 0) $display("FAIL lat_width got %0d wide pulses want 0", wide_valid); else passed++;
  endtask

  initial begin
    test_reset();
    test_standard();
    test_short();
    test_exact();
    test_startup_midright();
    test_random();
    test_midreset();
    test_latency();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Absolute time bound so the run always ends
  initial begin
    #3000000;
    $display("FAIL timeout got no completion want completion");
    $fatal(1, "timeout");
  end

endmodule
